// File: rtl/vga_timing_pkg.sv
// Shared raster constants for the VGA timing generator (640x480@60 defaults).
package vga_timing_pkg;

   // Coordinate and frame counter widths
   localparam int unsigned COORD_W     = 11;
   localparam int unsigned FRAME_CNT_W = 16;

   // Horizontal defaults (pixels)
   localparam int unsigned H_ACTIVE_DEF = 640;
   localparam int unsigned H_FP_DEF     = 16;
   localparam int unsigned H_SYNC_DEF   = 96;
   localparam int unsigned H_BP_DEF     = 48;

   // Vertical defaults (lines)
   localparam int unsigned V_ACTIVE_DEF = 480;
   localparam int unsigned V_FP_DEF     = 10;
   localparam int unsigned V_SYNC_DEF   = 2;
   localparam int unsigned V_BP_DEF     = 33;

   // Sync/blank lag behind the coordinates, in pixel-enable steps
   localparam int unsigned PIPE_DLY_DEF = 1;

   // Total span of one axis: active + front porch + sync + back porch
   function automatic int unsigned axis_total(input int unsigned active,
                                              input int unsigned fp,
                                              input int unsigned sync,
                                              input int unsigned bp);
      return active + fp + sync + bp;
   endfunction

   localparam int unsigned H_TOTAL_DEF  = axis_total(H_ACTIVE_DEF, H_FP_DEF, H_SYNC_DEF, H_BP_DEF);
   localparam int unsigned V_TOTAL_DEF  = axis_total(V_ACTIVE_DEF, V_FP_DEF, V_SYNC_DEF, V_BP_DEF);
   localparam int unsigned HS_START_DEF = H_ACTIVE_DEF + H_FP_DEF;
   localparam int unsigned HS_END_DEF   = HS_START_DEF + H_SYNC_DEF;
   localparam int unsigned VS_START_DEF = V_ACTIVE_DEF + V_FP_DEF;
   localparam int unsigned VS_END_DEF   = VS_START_DEF + V_SYNC_DEF;

endpackage

// File: rtl/vga_timing_gen_sync_delay_line.sv
// Enable-gated shift register that lags sync/blank behind the coordinates.
module sync_delay_line
   import vga_timing_pkg::*;
#(
   parameter int unsigned DEPTH = 1,
   parameter int unsigned WIDTH = 3
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             en,
   input  logic [WIDTH-1:0] rst_val,
   input  logic [WIDTH-1:0] din,
   output logic [WIDTH-1:0] dout
);

   logic [WIDTH-1:0] stage_q [DEPTH];
   logic [WIDTH-1:0] stage_d [DEPTH];

   // Shift one stage per enabled pixel, otherwise hold
   always_comb begin
      stage_d = stage_q;
      if (en) begin
         stage_d[0] = din;
         for (int unsigned i = 1; i < DEPTH; i++) begin
            stage_d[i] = stage_q[i-1];
         end
      end
   end

   // Stage registers; reset flushes every stage to the idle value
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         for (int unsigned i = 0; i < DEPTH; i++) begin
            stage_q[i] <= rst_val;
         end
      end else begin
         stage_q <= stage_d;
      end
   end

   assign dout = stage_q[DEPTH-1];

endmodule

// File: rtl/vga_timing_gen.sv
// Raster timing generator: pixel coordinates, frame-stable video mode,
// and delayed HS/VS/BLANK_N aligned to the overlay's registered RGB.
module vga_timing_gen
   import vga_timing_pkg::*;
#(
   parameter int unsigned H_ACTIVE = H_ACTIVE_DEF,
   parameter int unsigned H_FP     = H_FP_DEF,
   parameter int unsigned H_SYNC   = H_SYNC_DEF,
   parameter int unsigned H_BP     = H_BP_DEF,
   parameter int unsigned V_ACTIVE = V_ACTIVE_DEF,
   parameter int unsigned V_FP     = V_FP_DEF,
   parameter int unsigned V_SYNC   = V_SYNC_DEF,
   parameter int unsigned V_BP     = V_BP_DEF,
   parameter int unsigned PIPE_DLY = PIPE_DLY_DEF
) (
   input  logic                   iCLK,
   input  logic                   iRST_N,
   input  logic                   iPix_En,
   input  logic                   iVideo_Req,
   output logic [COORD_W-1:0]     oVga_x,
   output logic [COORD_W-1:0]     oVga_y,
   output logic                   oVideo_On,
   output logic                   oActive,
   output logic                   oHS,
   output logic                   oVS,
   output logic                   oBLANK_N,
   output logic                   oSYNC_N,
   output logic                   oFrame_Start,
   output logic [FRAME_CNT_W-1:0] oFrame_Cnt
);

   localparam int unsigned H_TOTAL = axis_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
   localparam int unsigned V_TOTAL = axis_total(V_ACTIVE, V_FP, V_SYNC, V_BP);

   localparam logic [COORD_W-1:0] X_LAST     = COORD_W'(H_TOTAL - 1);
   localparam logic [COORD_W-1:0] Y_LAST     = COORD_W'(V_TOTAL - 1);
   localparam logic [COORD_W-1:0] X_ACT_END  = COORD_W'(H_ACTIVE);
   localparam logic [COORD_W-1:0] Y_ACT_END  = COORD_W'(V_ACTIVE);
   localparam logic [COORD_W-1:0] HS_START_X = COORD_W'(H_ACTIVE + H_FP);
   localparam logic [COORD_W-1:0] HS_END_X   = COORD_W'(H_ACTIVE + H_FP + H_SYNC);
   localparam logic [COORD_W-1:0] VS_START_Y = COORD_W'(V_ACTIVE + V_FP);
   localparam logic [COORD_W-1:0] VS_END_Y   = COORD_W'(V_ACTIVE + V_FP + V_SYNC);

   // Idle delay-line word {hs, vs, blank_n}: syncs inactive, blanked
   localparam logic [2:0] DLY_IDLE = 3'b110;

   logic [COORD_W-1:0]     x_q, x_d, y_q, y_d;
   logic                   req_meta_q, req_meta_d, req_sync_q, req_sync_d;
   logic                   video_on_q, video_on_d;
   logic                   frame_start_q, frame_start_d;
   logic [FRAME_CNT_W-1:0] frame_cnt_q, frame_cnt_d;
   logic                   at_x_last, at_y_last, wrap;
   logic                   active, hs_raw, vs_raw;
   logic [2:0]             dly_in, dly_out;

   // Next-state: raster counters, request synchronizer, frame bookkeeping
   always_comb begin
      at_x_last     = (x_q == X_LAST);
      at_y_last     = (y_q == Y_LAST);
      wrap          = iPix_En && at_x_last && at_y_last;
      x_d           = x_q;
      y_d           = y_q;
      req_meta_d    = iVideo_Req;
      req_sync_d    = req_meta_q;
      video_on_d    = video_on_q;
      frame_cnt_d   = frame_cnt_q;
      // Pulse is recomputed every iCLK, so it lasts one clock even when
      // the pixel enable stays low after the wrap
      frame_start_d = wrap;
      if (iPix_En) begin
         if (at_x_last) begin
            x_d = '0;
            y_d = at_y_last ? '0 : y_q + 1'b1;
         end else begin
            x_d = x_q + 1'b1;
         end
      end
      if (wrap) begin
         video_on_d  = req_sync_q;
         frame_cnt_d = frame_cnt_q + 1'b1;
      end
   end

   // State registers with synchronous active-low reset
   always_ff @(posedge iCLK) begin
      if (!iRST_N) begin
         x_q           <= '0;
         y_q           <= '0;
         req_meta_q    <= 1'b0;
         req_sync_q    <= 1'b0;
         video_on_q    <= 1'b0;
         frame_start_q <= 1'b0;
         frame_cnt_q   <= '0;
      end else begin
         x_q           <= x_d;
         y_q           <= y_d;
         req_meta_q    <= req_meta_d;
         req_sync_q    <= req_sync_d;
         video_on_q    <= video_on_d;
         frame_start_q <= frame_start_d;
         frame_cnt_q   <= frame_cnt_d;
      end
   end

   // Undelayed active-area and sync decode from the current counters
   always_comb begin
      active = (x_q < X_ACT_END) && (y_q < Y_ACT_END);
      hs_raw = !((x_q >= HS_START_X) && (x_q < HS_END_X));
      vs_raw = !((y_q >= VS_START_Y) && (y_q < VS_END_Y));
      dly_in = {hs_raw, vs_raw, active};
   end

   sync_delay_line #(
      .DEPTH (PIPE_DLY),
      .WIDTH (3)
   ) u_sync_dly (
      .clk     (iCLK),
      .rst_n   (iRST_N),
      .en      (iPix_En),
      .rst_val (DLY_IDLE),
      .din     (dly_in),
      .dout    (dly_out)
   );

   assign oVga_x       = x_q;
   assign oVga_y       = y_q;
   assign oVideo_On    = video_on_q;
   assign oActive      = active;
   assign oHS          = dly_out[2];
   assign oVS          = dly_out[1];
   assign oBLANK_N     = dly_out[0];
   assign oSYNC_N      = 1'b0;
   assign oFrame_Start = frame_start_q;
   assign oFrame_Cnt   = frame_cnt_q;

endmodule
